data_array_writer: RTL and testbench

- Write-side counterpart of the shared read-only data array that the jimmy cores scan through their memory address/data port pairs.
- Accepts a byte stream over a valid/ready handshake and writes it into an internal 256x8 array. It then computes each core's start address and releases the two cores.
- Collects both cores' completion flags and reports job completion.
- Sits between a byte source (loader/UART front end) and the two cores; it replaces the fixed ROM plus hard-coded start addresses.

---
 rtl/data_array_pkg.sv | 18 +
 rtl/dual_read_ram.sv | 30 +++
 rtl/data_array_writer.sv | 147 ++++++++++++++
 tb/tb_data_array_writer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_array_pkg.sv
// Shared definitions for the data array writer: default widths, array depth
// and the controller state encoding.
package data_array_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEPTH          = 2 ** DEFAULT_ADDR_W;

  // Controller states; the encoding is also driven out on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SPLIT = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dual_read_ram.sv
// Byte array with one synchronous write port and two asynchronous read
// ports. Contents have no reset. A read of the address being written in the
// same cycle sees the old value because the write lands on the clock edge.
module dual_read_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_0,
  output logic [DATA_W-1:0] o_rdata_0,
  input  logic [ADDR_W-1:0] i_raddr_1,
  output logic [DATA_W-1:0] o_rdata_1
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Store the incoming byte on an accepted write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_0 = r_mem[i_raddr_0];
  assign o_rdata_1 = r_mem[i_raddr_1];

endmodule

// File: rtl/data_array_writer.sv
// Loads a byte stream into the shared data array, splits the loaded region
// between the two cores, releases them and reports joint completion.
//
// Write handshake: a byte is transferred on a rising edge where both
// wr_valid and wr_ready are high; wr_ready is high only in LOAD and does
// not depend on wr_valid.
//
// Optional feature: define DATA_ARRAY_WRITER_CHECKSUM_EN to enable the
// running byte checksum; otherwise checksum is tied to zero.
module data_array_writer
  import data_array_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] mem_addr_0,
  output logic [DATA_W-1:0] mem_data_0,
  input  logic [ADDR_W-1:0] mem_addr_1,
  output logic [DATA_W-1:0] mem_data_1,
  output logic [ADDR_W-1:0] start_addr_0,
  output logic [ADDR_W-1:0] start_addr_1,
  output logic              cores_go,
  input  logic              core_done_0,
  input  logic              core_done_1,
  output logic              all_done,
  output logic              busy,
  output logic [DATA_W-1:0] checksum,
  output state_t            dbg_state
);

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_start_addr_0;
  logic [ADDR_W-1:0] r_start_addr_1;
  logic              w_load_req;
  logic              w_accept;
  logic              w_last;

  assign w_load_req = (r_state == ST_IDLE) && load_start;
  assign wr_ready   = (r_state == ST_LOAD);
  assign w_accept   = wr_valid && wr_ready;
  assign w_last     = w_accept && ((r_count + CNT_ONE) == r_len);

  assign cores_go     = (r_state == ST_RUN);
  assign all_done     = (r_state == ST_DONE);
  assign busy         = (r_state != ST_IDLE);
  assign start_addr_0 = r_start_addr_0;
  assign start_addr_1 = r_start_addr_1;
  assign dbg_state    = r_state;

  // Next-state selection for the load / split / run / done sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (load_start) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_last) w_state_nxt = ST_SPLIT;
      ST_SPLIT: w_state_nxt = ST_RUN;
      ST_RUN:   if (core_done_0 && core_done_1) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Length latch (0 means full depth), byte count and write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len    <= '0;
      r_count  <= '0;
      r_wr_ptr <= '0;
    end else if (w_load_req) begin
      r_len    <= (load_len == '0) ? FULL_LEN : {1'b0, load_len};
      r_count  <= '0;
      r_wr_ptr <= '0;
    end else if (w_accept) begin
      r_count  <= r_count + CNT_ONE;
      r_wr_ptr <= r_wr_ptr + PTR_ONE;
    end
  end

  // Core start addresses: core 1 begins at the midpoint of the loaded bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_addr_0 <= '0;
      r_start_addr_1 <= '0;
    end else if (r_state == ST_SPLIT) begin
      r_start_addr_0 <= '0;
      r_start_addr_1 <= r_len[ADDR_W:1];
    end
  end

`ifdef DATA_ARRAY_WRITER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Running modulo sum of accepted bytes, cleared when a load begins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if (w_load_req) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + wr_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  dual_read_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .i_we      (w_accept),
    .i_waddr   (r_wr_ptr),
    .i_wdata   (wr_data),
    .i_raddr_0 (mem_addr_0),
    .o_rdata_0 (mem_data_0),
    .i_raddr_1 (mem_addr_1),
    .o_rdata_1 (mem_data_1)
  );

endmodule

// File: tb/tb_data_array_writer.sv
// Self-checking bench for data_array_writer. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
`timescale 1ns/1ps
module tb_data_array_writer;
  import data_array_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_start = 1'b0;
  logic [7:0] load_len = '0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] mem_addr_0 = '0;
  logic [7:0] mem_data_0;
  logic [7:0] mem_addr_1 = '0;
  logic [7:0] mem_data_1;
  logic [7:0] start_addr_0;
  logic [7:0] start_addr_1;
  logic       cores_go;
  logic       core_done_0 = 1'b0;
  logic       core_done_1 = 1'b0;
  logic       all_done;
  logic       busy;
  logic [7:0] checksum;
  state_t     dbg_state;

  data_array_writer dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_len     (load_len),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .mem_addr_0   (mem_addr_0),
    .mem_data_0   (mem_data_0),
    .mem_addr_1   (mem_addr_1),
    .mem_data_1   (mem_data_1),
    .start_addr_0 (start_addr_0),
    .start_addr_1 (start_addr_1),
    .cores_go     (cores_go),
    .core_done_0  (core_done_0),
    .core_done_1  (core_done_1),
    .all_done     (all_done),
    .busy         (busy),
    .checksum     (checksum),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];     // bytes to be sent in the next load
  int         valid_pat[$]; // optional fixed wr_valid pattern
  logic [7:0] ref_mem[256];
  bit         ref_known[256];
  logic [7:0] exp_sa1 = '0; // start_addr_1 the DUT should currently show

  function automatic logic [7:0] model_csum(input logic [7:0] sum);
`ifdef DATA_ARRAY_WRITER_CHECKSUM_EN
    return sum;
`else
    return 8'h00;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_random(input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Compare every known array location through both read ports.
  task automatic check_mem(input string tag);
    int bad0;
    int bad1;
    bad0 = 0;
    bad1 = 0;
    for (int a = 0; a < 256; a++) begin
      mem_addr_0 = 8'(a);
      mem_addr_1 = 8'(255 - a);
      #0.01;
      if (ref_known[a] && mem_data_0 !== ref_mem[a]) begin
        bad0++;
        $display("FAIL %s mem_data_0[%0d]: got %h want %h", tag, a, mem_data_0, ref_mem[a]);
      end
      if (ref_known[255 - a] && mem_data_1 !== ref_mem[255 - a]) begin
        bad1++;
        $display("FAIL %s mem_data_1[%0d]: got %h want %h", tag, 255 - a, mem_data_1, ref_mem[255 - a]);
      end
    end
    n_checks += 2;
    if (bad0 != 0) n_fail++;
    if (bad1 != 0) n_fail++;
  endtask

  // Start a load of len bytes from exp_q and follow it into RUN.
  task automatic do_load(input int len, input bit gaps, input string tag);
    int         idx;
    int         cyc;
    int         budget;
    int         not_ready;
    int         stale_rd;
    logic [7:0] sum;
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 8'(len);
    @(negedge clk);
    load_start = 1'b0;
    n_checks++;
    if (checksum !== 8'h00) begin
      n_fail++;
      $display("FAIL %s checksum_clear: got %h want 00", tag, checksum);
    end
    n_checks++;
    if (start_addr_1 !== exp_sa1) begin
      n_fail++;
      $display("FAIL %s start_addr_1_hold: got %h want %h", tag, start_addr_1, exp_sa1);
    end
    idx = 0; cyc = 0; not_ready = 0; stale_rd = 0; sum = 8'h00;
    budget = len * 6 + 20;
    while (idx < len && budget > 0) begin
      if (valid_pat.size() > 0) wr_valid = (valid_pat.pop_front() != 0);
      else if (gaps)            wr_valid = ($urandom_range(0, 2) != 0);
      else                      wr_valid = 1'b1;
      wr_data    = exp_q[idx];
      mem_addr_0 = 8'(idx);
      #0.01;
      cyc++;
      if (wr_ready !== 1'b1) not_ready++;
      if (ref_known[idx] && mem_data_0 !== ref_mem[idx]) stale_rd++;
      if (wr_valid) begin
        ref_mem[idx]   = wr_data;
        ref_known[idx] = 1'b1;
        sum            = sum + wr_data;
        idx++;
      end
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL %s load_timeout: got %0d bytes want %0d", tag, idx, len);
    end
    n_checks++;
    if (not_ready != 0) begin
      n_fail++;
      $display("FAIL %s wr_ready_in_load: got %0d low cycles want 0 of %0d", tag, not_ready, cyc);
    end
    n_checks++;
    if (stale_rd != 0) begin
      n_fail++;
      $display("FAIL %s read_during_write: got %0d wrong reads want 0", tag, stale_rd);
    end
    // One cycle after the final accept: SPLIT, no longer accepting.
    wr_valid = 1'b1;
    wr_data  = 8'($urandom_range(0, 255));
    n_checks++;
    if (wr_ready !== 1'b0 || cores_go !== 1'b0 || busy !== 1'b1 || dbg_state !== ST_SPLIT) begin
      n_fail++;
      $display("FAIL %s split_cycle: got ready=%b go=%b busy=%b st=%0d want 0 0 1 %0d",
               tag, wr_ready, cores_go, busy, dbg_state, ST_SPLIT);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    exp_sa1  = 8'(len >> 1);
    n_checks++;
    if (cores_go !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s cores_go_rise: got go=%b ready=%b want 1 0", tag, cores_go, wr_ready);
    end
    n_checks++;
    if (start_addr_0 !== 8'h00 || start_addr_1 !== exp_sa1) begin
      n_fail++;
      $display("FAIL %s start_addr: got %h/%h want 00/%h", tag, start_addr_0, start_addr_1, exp_sa1);
    end
    n_checks++;
    if (checksum !== model_csum(sum)) begin
      n_fail++;
      $display("FAIL %s checksum: got %h want %h", tag, checksum, model_csum(sum));
    end
  endtask

  // Raise core_done_0 after d0 cycles and core_done_1 after d1 cycles.
  task automatic run_complete(input int d0, input int d1, input string tag);
    int cyc;
    int bad;
    cyc = 0; bad = 0;
    @(negedge clk);
    load_start = 1'b1;   // must be ignored outside IDLE
    load_len   = 8'd7;
    forever begin
      core_done_0 = (cyc >= d0);
      core_done_1 = (cyc >= d1);
      if (cores_go !== 1'b1 || all_done !== 1'b0 || busy !== 1'b1) bad++;
      if (core_done_0 && core_done_1) break;
      @(negedge clk);
      load_start = 1'b0;
      cyc++;
    end
    load_start = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s run_hold: got %0d bad cycles want 0", tag, bad);
    end
    @(negedge clk);
    n_checks++;
    if (all_done !== 1'b1 || cores_go !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_cycle: got done=%b go=%b busy=%b want 1 0 1", tag, all_done, cores_go, busy);
    end
    core_done_0 = 1'b0;
    core_done_1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (all_done !== 1'b0 || busy !== 1'b0 || cores_go !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after: got done=%b busy=%b go=%b want 0 0 0", tag, all_done, busy, cores_go);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s no_queued_load: got busy=%b ready=%b want 0 0", tag, busy, wr_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b0 || cores_go !== 1'b0 || all_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%b go=%b done=%b busy=%b want 0 0 0 0",
               wr_ready, cores_go, all_done, busy);
    end
    n_checks++;
    if (start_addr_0 !== 8'h00 || start_addr_1 !== 8'h00 || checksum !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_regs: got sa0=%h sa1=%h cs=%h want 00 00 00", start_addr_0, start_addr_1, checksum);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_load();
    exp_q = '{8'h03, 8'h08, 8'h10, 8'h07};
    do_load(4, 1'b0, "basic");
    check_mem("basic");
    run_complete(2, 2, "basic_done");
  endtask

  task automatic test_full_depth();
    fill_random(256);
    do_load(256, 1'b0, "full");
    check_mem("full");
    run_complete(0, 0, "full_done");
  endtask

  task automatic test_gaps();
    exp_q = '{8'hA1, 8'hB2, 8'hC3};
    valid_pat = '{1, 0, 0, 1, 0, 1};
    do_load(3, 1'b0, "gaps");
    check_mem("gaps");
    run_complete(3, 1, "gaps_done");
  endtask

  task automatic test_completion_order();
    fill_random(5);
    do_load(5, 1'b1, "order");
    run_complete(10, 0, "order_1_first");
  endtask

  task automatic test_reset_mid_load();
    int acc;
    fill_random(5);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 8'd5;
    @(negedge clk);
    load_start = 1'b0;
    acc = 0;
    while (acc < 2) begin
      wr_valid = 1'b1;
      wr_data  = exp_q[acc];
      ref_mem[acc]   = exp_q[acc];
      ref_known[acc] = 1'b1;
      acc++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    reset    = 1'b0;
    #1;
    exp_sa1 = 8'h00;
    n_checks++;
    if (wr_ready !== 1'b0 || busy !== 1'b0 || cores_go !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL midreset_idle: got ready=%b busy=%b go=%b st=%0d want 0 0 0 0",
               wr_ready, busy, cores_go, dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
    check_mem("midreset");
    exp_q = '{8'h5A, 8'hC7};
    do_load(2, 1'b0, "after_reset");
    check_mem("after_reset");
    run_complete(1, 4, "after_reset_done");
  endtask

  task automatic test_checksum();
    exp_q = '{8'hF0, 8'h20, 8'h05};
    do_load(3, 1'b0, "csum");
`ifdef DATA_ARRAY_WRITER_CHECKSUM_EN
    n_checks++;
    if (checksum !== 8'h15) begin
      n_fail++;
      $display("FAIL csum_value: got %h want 15", checksum);
    end
`endif
    run_complete(0, 2, "csum_done");
    n_checks++;
    if (checksum !== model_csum(8'h15)) begin
      n_fail++;
      $display("FAIL csum_hold: got %h want %h", checksum, model_csum(8'h15));
    end
  endtask

  task automatic test_random_loads();
    int len;
    for (int it = 0; it < 6; it++) begin
      len = (it == 0) ? 1 : $urandom_range(1, 40);
      fill_random(len);
      do_load(len, 1'b1, $sformatf("rand%0d", it));
      check_mem($sformatf("rand%0d", it));
      run_complete($urandom_range(0, 8), $urandom_range(0, 8), $sformatf("rand%0d_done", it));
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 8'h00;
      ref_known[i] = 1'b0;
    end
    test_reset();
    test_basic_load();
    test_full_depth();
    test_gaps();
    test_completion_order();
    test_reset_mid_load();
    test_checksum();
    test_random_loads();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
